// File: rtl/symmetry_generator.sv
// symmetry_generator: latches {half_in, bit-reversed half_in} (bit0 optionally flipped by corrupt) and shifts it out MSB-first; in: clk, rst, start, half_in, corrupt; out: word_out, ser_out, ser_valid, busy, done
module symmetry_generator #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N/2-1:0] half_in,
  input  logic           corrupt,
  output logic [N-1:0]   word_out,
  output logic           ser_out,
  output logic           ser_valid,
  output logic           busy,
  output logic           done
);
  localparam int H = N / 2;
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  word_q;
  logic          ser_q, valid_q, busy_q, done_q;
  logic [H-1:0]  rev;
  logic [N-1:0]  word_d;
  for (genvar i = 0; i < H; i++) begin : g_rev
    assign rev[i] = half_in[H-1-i];
  end
  assign word_d = {half_in, rev} ^ N'(corrupt);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
      ser_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SHIFT;
          word_q  <= word_d;
          cnt_q   <= '0;
          ser_q   <= word_d[N-1];
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        SHIFT: if (cnt_q == CW'(N - 1)) begin
          state_q <= DONE;
          ser_q   <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
          ser_q <= word_q[CW'(N - 2) - cnt_q];
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign word_out  = word_q;
  assign ser_out   = ser_q;
  assign ser_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_symmetry_generator.sv
// tb_symmetry_generator: scoreboard bench with a behavioural palindrome model and serial loopback detector
module tb_symmetry_generator;
  localparam int N = 8;
  localparam int H = N / 2;
  typedef struct {
    logic [N-1:0] w;
    logic         c;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, corrupt = 1'b0;
  logic [H-1:0] half_in = '0;
  logic [N-1:0] word_out;
  logic ser_out, ser_valid, busy, done;
  int tests = 0, fails = 0;
  exp_t exp_q[$];
  logic bits[$];
  symmetry_generator #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .half_in(half_in), .corrupt(corrupt),
    .word_out(word_out), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [N-1:0] model(input logic [H-1:0] h, input logic c);
    logic [N-1:0] w;
    for (int i = 0; i < H; i++) begin
      w[N-1-i] = h[H-1-i];
      w[i]     = h[H-1-i];
    end
    w[0] = w[0] ^ c;
    return w;
  endfunction
  // Monitor: gathers serial bits, acts as the symmetry detector, and scores each frame on done
  always @(negedge clk) begin
    if (rst) bits.delete();
    else begin
      if (!ser_valid) chk("ser_out_when_invalid", ser_out, 0);
      chk("busy", busy, ser_valid | done);
      if (ser_valid) bits.push_back(ser_out);
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done with no frame pending");
        end else begin
          exp_t e;
          logic [N-1:0] sw;
          logic pal;
          e = exp_q.pop_front();
          sw = '0;
          pal = 1'b1;
          chk("frame_len", bits.size(), N);
          if (bits.size() == N) begin
            for (int i = 0; i < N; i++) sw[N-1-i] = bits[i];
            for (int i = 0; i < H; i++) if (bits[i] !== bits[N-1-i]) pal = 1'b0;
          end
          chk("serial_word", sw, e.w);
          chk("word_out", word_out, e.w);
          chk("symmetry_verdict", pal, !e.c);
        end
        bits.delete();
      end
    end
  end
  task automatic frame(input logic [H-1:0] h, input logic c, input bit glitch);
    bit got = 0;
    @(posedge clk) #1;
    half_in = h;
    corrupt = c;
    start = 1'b1;
    exp_q.push_back('{model(h, c), c});
    @(posedge clk) #1;
    start = 1'b0;
    half_in = H'($urandom);
    corrupt = 1'($urandom);
    for (int i = 1; i <= N + 4 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        chk("done_latency", i, N + 1);
      end
      if (glitch && i == 3) begin
        start = 1'b1;
        half_in = '0;
      end else start = 1'b0;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got no done expected done within %0d cycles", N + 4);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_word_out"}, word_out, 0);
    chk({n, "_ser_out"}, ser_out, 0);
    chk({n, "_ser_valid"}, ser_valid, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_done"}, done, 0);
  endtask
  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    frame(4'b1011, 1'b0, 0);
    chk("directed_sym_word", word_out, 8'b1011_1101);
    frame(4'b1011, 1'b1, 0);
    chk("directed_corrupt_word", word_out, 8'b1011_1100);
    frame(4'b1011, 1'b0, 1);
    chk("restart_ignored_word", word_out, 8'b1011_1101);
    // abort in SHIFT cycle 5
    @(posedge clk) #1;
    half_in = H'($urandom);
    corrupt = 1'($urandom);
    start = 1'b1;
    exp_q.push_back('{model(half_in, corrupt), corrupt});
    @(posedge clk) #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk_zero("abort");
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);
    frame(4'b0110, 1'b0, 0);
    // start held through reset release, then continuously
    @(posedge clk) #1;
    rst = 1'b1;
    start = 1'b1;
    half_in = 4'b0001;
    corrupt = 1'b0;
    exp_q.delete();
    repeat (3) exp_q.push_back('{model(4'b0001, 1'b0), 1'b0});
    @(posedge clk) #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 3 * (N + 2) + 10 && cnt < 3; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        chk("held_start_period", i, cnt * (N + 2));
        chk("held_start_word", word_out, 8'b0001_1000);
        if (cnt == 3) start = 1'b0;
      end
    end
    chk("held_start_frames", cnt, 3);
    start = 1'b0;
    for (int h = 0; h < 16; h++) begin
      frame(H'(h), 1'b0, 0);
      frame(H'(h), 1'b1, 0);
    end
    for (int k = 0; k < 40; k++) frame(H'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    repeat (N + 4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/symmetry_generator.md
SYMMETRY_GENERATOR -- requirements
Module: symmetry_generator

Interface
REQ-001 SHALL provide parameter N, default 8, meaning total word width in bits; legal values are even and >= 4.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst, input, 1; one clock; reset is synchronous and active-high.
REQ-004 SHALL provide port start, input, 1, request to build and transmit one word; sampled only in IDLE.
REQ-005 SHALL provide port half_in, input, N/2, upper half of the word to mirror.
REQ-006 SHALL provide port corrupt, input, 1, sampled with start; forces an asymmetric word for negative testing.
REQ-007 SHALL provide port word_out, output, N, latched parallel word.
REQ-008 SHALL provide port ser_out, output, 1, serial data bit, MSB first.
REQ-009 SHALL provide port ser_valid, output, 1, high while ser_out carries a word bit.
REQ-010 SHALL provide port busy, output, 1, high in SHIFT and DONE.
REQ-011 SHALL provide port done, output, 1, single-cycle completion pulse.

Function
REQ-012 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL transition from IDLE to SHIFT on the first edge with start=1, else remain in IDLE.
REQ-014 On that edge, SHALL latch word_out[N-1:N/2] = half_in and word_out[N/2-1:0] = bit-reverse of half_in (word_out[i] = word_out[N-1-i] for all i).
REQ-015 When corrupt=1 at that edge, SHALL additionally invert word_out[0], so the word is never symmetric.
REQ-016 In SHIFT, SHALL drive ser_valid=1 and ser_out = word_out[N-1-k], where k is the bit counter, 0..N-1.
REQ-017 SHALL size the bit counter to clog2(N) bits, clear it on entry to SHIFT, and increment it once per cycle in SHIFT.
REQ-018 SHALL transition SHIFT to DONE in the cycle after k=N-1 is presented (exactly N ser_valid cycles).
REQ-019 In DONE, SHALL hold done=1 and ser_valid=0 for one cycle, then return to IDLE.
REQ-020 Latency: start sampled at edge t -> ser_valid high for cycles t+1..t+N -> done high in cycle t+N+1 -> IDLE at t+N+2.
REQ-021 SHALL ignore start while busy=1; no queuing and no restart.
REQ-022 SHALL ignore changes to half_in and corrupt outside the start edge; word_out is stable from latch until the next accepted start.
REQ-023 SHALL accept start asserted in the first IDLE cycle after DONE, giving back-to-back words with a 1-cycle gap of ser_valid=0 beyond the DONE cycle.
REQ-024 SHALL drive ser_out=0 whenever ser_valid=0.
REQ-025 SHALL register all outputs; no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1 at a clock edge, SHALL force state=IDLE, counter=0, word_out=0, ser_out=0, ser_valid=0, busy=0, done=0.
REQ-027 SHALL take priority for rst over start; rst during SHIFT or DONE aborts the word with no done pulse.
REQ-028 SHALL ignore a start held through the edge where rst falls; the first start is sampled on the following edge.

Verification
REQ-029 N=8, half_in=4'b1011, corrupt=0, start pulse -> word_out=8'b1011_1101, ser_out sequence 1,0,1,1,1,1,0,1 over 8 ser_valid cycles, then done pulse.
REQ-030 N=8, half_in=4'b1011, corrupt=1 -> word_out=8'b1011_1100, last serial bit 0, done after 8 bits.
REQ-031 start re-pulsed in SHIFT cycle 3 with half_in=4'b0000 -> transmission unchanged, word_out still 8'b1011_1101, exactly one done.
REQ-032 rst=1 in SHIFT cycle 5 -> next cycle all outputs 0, no done; a later start produces a full 8-bit frame.
REQ-033 start held high continuously, half_in=4'b0001 -> frames repeat every N+2 cycles, word_out=8'b0001_1000, ser_valid low in DONE and in the IDLE cycle between frames.
REQ-034 Loopback: ser_out/ser_valid feed the team's symmetry detector -> symmetric verdict for corrupt=0 and asymmetric for corrupt=1 over all 16 half_in values.
